// File: rtl/mips_fetch_if.sv
// Instruction-memory request/acknowledge bus between mips_fetch (master) and memory (slave).
interface mips_fetch_if;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_data_in;

  modport master (
    output imem_req_out,
    output imem_addr_out,
    input  imem_ack_in,
    input  imem_data_in
  );

  modport slave (
    input  imem_req_out,
    input  imem_addr_out,
    output imem_ack_in,
    output imem_data_in
  );
endinterface

// File: rtl/mips_fetch.sv
// MIPS fetch stage: PC, imem req/ack handshake, instruction register and next-PC selection.
// Optional fetch/redirect statistics counters are enabled by defining MIPS_FETCH_STATS_EN.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  mips_fetch_if.master     imem,
  output logic             instr_valid_out,
  output logic [31:0]      instr_out,
  output logic [5:0]       op_out,
  output logic [5:0]       func_out,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4_out,
  input  logic             instr_accept_in,
  input  logic             branch_in,
  input  logic             bne_in,
  input  logic             jump_in,
  input  logic             zero_in,
  output logic [31:0]      fetch_count_out,
  output logic [CNT_W-1:0] redirect_count_out
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] pc_plus4, jtarget, btarget, next_pc;
  logic        ack_fetch, accept_hold;

  assign pc_plus4    = ipc_q + 32'd4;
  assign jtarget     = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  assign btarget     = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign ack_fetch   = (state_q == StFetch) && (imem.imem_ack_in == 1'b1);
  assign accept_hold = (state_q == StHold) && (instr_accept_in == 1'b1);

  // An X on a control input falls through to the sequential PC.
  always_comb begin
    next_pc = pc_plus4;
    if (jump_in) begin
      next_pc = jtarget;
    end else if (branch_in && zero_in) begin
      next_pc = btarget;
    end else if (bne_in && !zero_in) begin
      next_pc = btarget;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (ack_fetch) begin
          instr_d = imem.imem_data_in;
          ipc_d   = pc_q;
          state_d = StHold;
        end
      end
      StHold: begin
        if (accept_hold) begin
          pc_d    = next_pc;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      ipc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem.imem_req_out  = (state_q == StFetch);
  assign imem.imem_addr_out = pc_q;
  assign instr_valid_out    = (state_q == StHold);
  assign instr_out          = instr_q;
  assign op_out             = instr_q[31:26];
  assign func_out           = instr_q[5:0];
  assign pc_out             = ipc_q;
  assign pc_plus4_out       = pc_plus4;

`ifdef MIPS_FETCH_STATS_EN
  logic [31:0]      fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

  // Fetch count wraps; redirect count saturates at all-ones.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (ack_fetch) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (accept_hold && (next_pc != pc_plus4) && !(&redir_cnt_q)) begin
      redir_cnt_d = redir_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_q <= 32'd0;
      redir_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign fetch_count_out    = fetch_cnt_q;
  assign redirect_count_out = redir_cnt_q;
`else
  assign fetch_count_out    = 32'd0;
  assign redirect_count_out = '0;
`endif

endmodule

// File: tb/tb_mips_fetch.sv
// Self-checking bench for mips_fetch: memory responder, scoreboard of acked words, PC redirects.
module tb_mips_fetch;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int unsigned CNT_W    = 16;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             instr_valid_out;
  logic [31:0]      instr_out;
  logic [5:0]       op_out;
  logic [5:0]       func_out;
  logic [31:0]      pc_out;
  logic [31:0]      pc_plus4_out;
  logic             instr_accept_in;
  logic             branch_in;
  logic             bne_in;
  logic             jump_in;
  logic             zero_in;
  logic [31:0]      fetch_count_out;
  logic [CNT_W-1:0] redirect_count_out;

  mips_fetch_if imem_bus ();

  mips_fetch #(
    .RESET_PC (RESET_PC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .imem               (imem_bus),
    .instr_valid_out    (instr_valid_out),
    .instr_out          (instr_out),
    .op_out             (op_out),
    .func_out           (func_out),
    .pc_out             (pc_out),
    .pc_plus4_out       (pc_plus4_out),
    .instr_accept_in    (instr_accept_in),
    .branch_in          (branch_in),
    .bne_in             (bne_in),
    .jump_in            (jump_in),
    .zero_in            (zero_in),
    .fetch_count_out    (fetch_count_out),
    .redirect_count_out (redirect_count_out)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  exp_t last_e;
  int   n_checks      = 0;
  int   n_fail        = 0;
  int   exp_fetches   = 0;
  int   exp_redirects = 0;

  localparam logic [31:0] Beq = 32'h1022_FFFC;
  localparam logic [31:0] Bne = 32'h1422_0003;
  localparam logic [31:0] J1  = 32'h0810_0008;
  localparam logic [31:0] J2  = 32'h0810_0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req"}, 32'(imem_bus.imem_req_out), 32'd0);
    check_eq({tag, "_addr"}, imem_bus.imem_addr_out, RESET_PC);
    check_eq({tag, "_valid"}, 32'(instr_valid_out), 32'd0);
    check_eq({tag, "_instr"}, instr_out, 32'd0);
    check_eq({tag, "_opfunc"}, {20'd0, op_out, func_out}, 32'd0);
    check_eq({tag, "_pc"}, pc_out, RESET_PC);
    check_eq({tag, "_pc4"}, pc_plus4_out, RESET_PC + 32'd4);
    check_eq({tag, "_fcnt"}, fetch_count_out, 32'd0);
    check_eq({tag, "_rcnt"}, 32'(redirect_count_out), 32'd0);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (imem_bus.imem_req_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check_eq("req_timeout", 32'd0, 32'd1);
  endtask

  // Serve one request after `delay` wait cycles; accept is asserted meanwhile and must be ignored.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int delay);
    bit   ok;
    exp_t e;
    wait_req(ok);
    if (!ok) return;
    check_eq("fetch_addr", imem_bus.imem_addr_out, exp_addr);
    for (int i = 0; i < delay; i++) begin
      instr_accept_in = 1'b1;
      @(negedge clk);
      check_eq("addr_stable", imem_bus.imem_addr_out, exp_addr);
      check_eq("req_held", 32'(imem_bus.imem_req_out), 32'd1);
    end
    instr_accept_in       = 1'b0;
    imem_bus.imem_ack_in  = 1'b1;
    imem_bus.imem_data_in = word;
    e.instr = word;
    e.pc    = exp_addr;
    sb_q.push_back(e);
    exp_fetches++;
    @(negedge clk);
    imem_bus.imem_ack_in  = 1'b0;
    imem_bus.imem_data_in = 32'hDEAD_BEEF;
    check_eq("valid_after_ack", 32'(instr_valid_out), 32'd1);
    check_eq("req_drop", 32'(imem_bus.imem_req_out), 32'd0);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      last_e = sb_q.pop_front();
      check_eq("instr", instr_out, last_e.instr);
      check_eq("pc_out", pc_out, last_e.pc);
      check_eq("pc_plus4", pc_plus4_out, last_e.pc + 32'd4);
      check_eq("op", 32'(op_out), 32'(last_e.instr[31:26]));
      check_eq("func", 32'(func_out), 32'(last_e.instr[5:0]));
    end
  endtask

  // Hold for `hold` cycles (with a stray ack), then accept with the given decoder controls.
  task automatic accept(input int hold, input logic j, input logic b, input logic bn,
                        input logic z, input logic [31:0] exp_next);
    for (int i = 0; i < hold; i++) begin
      imem_bus.imem_ack_in  = 1'b1;
      imem_bus.imem_data_in = 32'hFFFF_FFFF;
      @(negedge clk);
      check_eq("hold_instr", instr_out, last_e.instr);
      check_eq("hold_pc", pc_out, last_e.pc);
      check_eq("hold_valid", 32'(instr_valid_out), 32'd1);
      check_eq("hold_noreq", 32'(imem_bus.imem_req_out), 32'd0);
    end
    imem_bus.imem_ack_in = 1'b0;
    jump_in         = j;
    branch_in       = b;
    bne_in          = bn;
    zero_in         = z;
    instr_accept_in = 1'b1;
    @(negedge clk);
    instr_accept_in = 1'b0;
    {jump_in, branch_in, bne_in, zero_in} = 4'b0000;
    check_eq("valid_clear", 32'(instr_valid_out), 32'd0);
    check_eq("req_after_acc", 32'(imem_bus.imem_req_out), 32'd1);
    check_eq("next_addr", imem_bus.imem_addr_out, exp_next);
    if (exp_next != last_e.pc + 32'd4) exp_redirects++;
  endtask

  task automatic check_stats(input string tag);
`ifdef MIPS_FETCH_STATS_EN
    check_eq({tag, "_fcnt"}, fetch_count_out, 32'(exp_fetches));
    check_eq({tag, "_rcnt"}, 32'(redirect_count_out), 32'(exp_redirects));
`else
    check_eq({tag, "_fcnt"}, fetch_count_out, 32'd0);
    check_eq({tag, "_rcnt"}, 32'(redirect_count_out), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset_n               = 1'b0;
    imem_bus.imem_ack_in  = 1'b0;
    imem_bus.imem_data_in = 32'd0;
    instr_accept_in       = 1'b0;
    {jump_in, branch_in, bne_in, zero_in} = 4'b0000;
    repeat (2) @(negedge clk);
    check_reset("rst");
    reset_n = 1'b1;

    // Three addi words, sequential fetch.
    for (int k = 0; k < 3; k++) begin
      fetch(RESET_PC + 32'(4 * k), 32'h2008_0000 | 32'(k), 0);
      check_eq("addi_op", 32'(op_out), 32'h08);
      accept(0, 1'b0, 1'b0, 1'b0, 1'b0, RESET_PC + 32'(4 * (k + 1)));
    end
    // Undefined (X) branch/zero must yield the sequential PC.
    fetch(32'h0040_000C, 32'd0, 0);
    accept(0, 1'b0, 1'bx, 1'b0, 1'bx, 32'h0040_0010);

    fetch(32'h0040_0010, Beq, 0);
    accept(0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0004);
    for (logic [31:0] a = 32'h0040_0004; a < 32'h0040_0010; a += 32'd4) begin
      fetch(a, 32'd0, 0);
      accept(0, 1'b0, 1'b0, 1'b0, 1'b0, a + 32'd4);
    end
    fetch(32'h0040_0010, Beq, 0);
    accept(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0014);
    for (logic [31:0] a = 32'h0040_0014; a < 32'h0040_0020; a += 32'd4) begin
      fetch(a, 32'd0, 0);
      accept(0, 1'b0, 1'b0, 1'b0, 1'b0, a + 32'd4);
    end

    fetch(32'h0040_0020, Bne, 0);
    accept(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0030);
    fetch(32'h0040_0030, J1, 0);
    accept(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0020);
    fetch(32'h0040_0020, Bne, 0);
    accept(0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0024);
    for (logic [31:0] a = 32'h0040_0024; a < 32'h0040_0040; a += 32'd4) begin
      fetch(a, 32'd0, 0);
      accept(0, 1'b0, 1'b0, 1'b0, 1'b0, a + 32'd4);
    end
    // Jump has priority over a taken beq.
    fetch(32'h0040_0040, J2, 0);
    accept(0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0000);
    check_stats("stats");

    // Slow memory and slow consumer, with ignored accept in FETCH and ack in HOLD.
    fetch(32'h0040_0000, 32'h2008_0005, 5);
    accept(4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0004);

    // Reset in the middle of FETCH with an ack arriving alongside.
    wait_req(ok);
    repeat (2) @(negedge clk);
    imem_bus.imem_ack_in  = 1'b1;
    imem_bus.imem_data_in = 32'h1234_5678;
    reset_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    check_reset("midrst_hold");
    reset_n = 1'b1;
    @(negedge clk);
    imem_bus.imem_ack_in = 1'b0;
    check_eq("late_ack_valid", 32'(instr_valid_out), 32'd0);
    check_eq("late_ack_instr", instr_out, 32'd0);
    check_eq("post_rst_req", 32'(imem_bus.imem_req_out), 32'd1);
    check_eq("post_rst_addr", imem_bus.imem_addr_out, RESET_PC);
    sb_q.delete();
    exp_fetches   = 0;
    exp_redirects = 0;
    fetch(RESET_PC, 32'h2008_0009, 0);
    accept(0, 1'b0, 1'b0, 1'b0, 1'b0, RESET_PC + 32'd4);
    check_stats("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_fetch.md
Name: mips_fetch

Overview:
- Instruction fetch stage directly upstream of the MIPS control decoder.
- Holds the PC and runs a req/ack handshake to instruction memory. Latches the returned word into an instruction register and presents op/func to the decoder.
- Computes the next PC from the decoder's branch/bne/jump outputs plus the ALU zero flag.

Parameters:
RESET_PC, 32'h0040_0000, PC loaded on reset; bits [1:0] must be 00
CNT_W, 16, width of the redirect counter (optional feature only)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
imem_req_out  out  1  fetch request to instruction memory
imem_addr_out  out  32  fetch address; always equals the current PC
imem_ack_in  in  1  memory returns data this cycle
imem_data_in  in  32  instruction word, valid when imem_ack_in=1
instr_valid_out  out  1  the instruction register holds an unconsumed instruction
instr_out  out  32  instruction register
op_out  out  6  instr_out[31:26], drives decoder op_in
func_out  out  6  instr_out[5:0], drives decoder func_in
pc_out  out  32  PC of the held instruction
pc_plus4_out  out  32  pc_out+4
instr_accept_in  in  1  downstream consumes the held instruction this cycle
branch_in  in  1  decoder branch_out (beq)
bne_in  in  1  decoder bne_out
jump_in  in  1  decoder jump_out
zero_in  in  1  ALU zero flag for the held instruction
fetch_count_out  out  32  optional feature
redirect_count_out  out  CNT_W  optional feature

Behaviour:
- Reset (reset_n=0, asynchronous), output values:
  - imem_req_out=0
  - pc and imem_addr_out=RESET_PC
  - instr_valid_out=0
  - instr_out=0, so op/func=0, which the decoder treats as nop
  - pc_out=RESET_PC, pc_plus4_out=RESET_PC+4
  - FSM=IDLE
- FSM states: IDLE, FETCH, HOLD.
  - IDLE -> FETCH on the first rising edge with reset_n=1. imem_req_out=1 from that edge.
  - FETCH: imem_req_out=1 and imem_addr_out=pc. On an edge with imem_ack_in=1:
    - instr_out<=imem_data_in
    - pc_out<=pc
    - instr_valid_out<=1
    - imem_req_out<=0
    - go to HOLD
  - FETCH with no ack: wait indefinitely; address held stable.
  - HOLD: instr_out, pc_out and instr_valid_out stay stable until instr_accept_in=1. On the accept edge:
    - pc<=next_pc
    - instr_valid_out<=0
    - go to FETCH; imem_req_out=1 from that edge
- Latency and throughput:
  - Ack edge -> instr_valid_out=1 on the same edge's output (registered).
  - Accept edge -> next request.
  - Minimum 2 cycles per instruction (zero-wait memory).
- next_pc, computed from the held instruction:
  - jtarget = {pc_plus4_out[31:28], instr_out[25:0], 2'b00}
  - btarget = pc_plus4_out + {{14{instr_out[15]}}, instr_out[15:0], 2'b00}, mod 2^32
  - Priority: jump_in -> jtarget; else branch_in & zero_in -> btarget; else bne_in & ~zero_in -> btarget; else pc_plus4_out.
- Sampling of decoder outputs:
  - branch_in, bne_in, jump_in and zero_in are sampled only on the accept edge.
  - A control input that is not 1 (including X from an undefined opcode) counts as 0, giving the sequential PC.
- Boundaries:
  - Ack while not in FETCH is ignored.
  - Accept while not in HOLD is ignored.
  - Simultaneous accept and ack cannot occur, because the states are disjoint.
  - PC 32'hFFFF_FFFC + 4 wraps to 0.
  - Backward branch (negative imm) wraps modulo 2^32.
  - PC bits [1:0] always 00.
- Reset mid-operation (FETCH or HOLD):
  - Immediate return to reset values.
  - The held instruction is discarded.
  - An ack arriving during or after reset, before the new FETCH, is ignored.

Optional Feature:
- Macro: MIPS_FETCH_STATS_EN.
- Defined:
  - fetch_count_out increments on every accepted ack and wraps.
  - redirect_count_out increments on each accept where next_pc != pc_plus4_out, and saturates at all-ones.
  - Both counters reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops exist. Ports are present in both builds.

Test Plan:
- Reset with RESET_PC=0x00400000, zero-wait memory, accept one cycle after valid, three addi words -> imem_addr_out sequence 0x00400000, 0x00400004, 0x00400008; instr_valid_out pulses; op_out=0x08 each time.
- beq at 0x00400010, imm=0xFFFC, branch_in=1, zero_in=1 at accept -> next fetch 0x00400004. Same case with zero_in=0 -> 0x00400014.
- bne at 0x00400020, imm=0x0003, bne_in=1, zero_in=0 -> next fetch 0x00400030. Same case with zero_in=1 -> 0x00400024.
- jump_in=1 together with branch_in=1, zero_in=1, instr[25:0]=0x0100000, pc=0x00400040 -> next fetch 0x00400000 (jump wins).
- Memory ack delayed 5 cycles; accept held low 4 cycles in HOLD -> imem_addr_out and instr_out stable throughout; no second request until accept. Then reset_n pulsed low mid-FETCH -> outputs return to reset values, and a late ack is ignored.
- With MIPS_FETCH_STATS_EN: 10 fetches including 3 taken redirects -> fetch_count_out=10, redirect_count_out=3. Without the macro: both read 0.
